adder_rr_arbiter: RTL and testbench

//  Shares one AXI-Stream adder pipeline between NUM_REQ requesters, each with its own stream.

---
 rtl/adder_rr_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_adder_rr_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter that shares one fixed-latency AXI-Stream adder between NUM_REQ streams.
// Define ADDER_ARB_PKT_LOCK_EN to hold the adder for one requester until its tlast beat.
module adder_rr_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REQ       = 2,
  parameter int ADDER_LATENCY = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_REQ*2*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_REQ-1:0]              s_axis_tvalid,
  input  logic [NUM_REQ-1:0]              s_axis_tlast,
  output logic [NUM_REQ-1:0]              s_axis_tready,
  output logic [2*DATA_WIDTH-1:0]         adder_tdata,
  output logic                            adder_tvalid,
  output logic                            adder_tlast,
  input  logic [DATA_WIDTH-1:0]           adder_res_tdata,
  input  logic                            adder_res_tvalid,
  input  logic                            adder_res_tlast,
  output logic [NUM_REQ*DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [NUM_REQ-1:0]              m_axis_tvalid,
  output logic [NUM_REQ-1:0]              m_axis_tlast,
  input  logic [NUM_REQ-1:0]              m_axis_tready,
  output logic                            lat_err
);

  localparam int DW   = DATA_WIDTH;
  localparam int IDW  = $clog2(NUM_REQ);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int TAGN = ADDER_LATENCY + 1;
  localparam int SW   = $clog2(FIFO_DEPTH + TAGN + 1);
  localparam int BW   = $clog2(TAGN + 1);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} arb_state_e;

  arb_state_e       state_q;
  logic [IDW-1:0]   rr_ptr_q, lock_id_q;
  logic [TAGN-1:0]  tag_vld_q;
  logic [IDW-1:0]   tag_id_q [TAGN];
  logic [IDW-1:0]   fifo_id_q [FIFO_DEPTH];
  logic [DW-1:0]    fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [SW-1:0]    count_q;
  logic [BW-1:0]    blank_q;
  logic [2*DW-1:0]  adder_tdata_q;
  logic             adder_tvalid_q, adder_tlast_q, lat_err_q;

  logic [2*DW-1:0]  s_data [NUM_REQ];
  logic [SW-1:0]    inflight;
  logic             credit, found, gid_last;
  logic [IDW-1:0]   gid, rr_ptr_d, head_id;
  logic             tail_vld, push, pop, fifo_empty, miss, stray;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) s_data[i] = s_axis_tdata[i*2*DW +: 2*DW];
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < TAGN; k++) inflight = inflight + SW'(tag_vld_q[k]);
  end

  // A slot is reserved for every beat still inside the adder, so the FIFO never overflows.
  assign credit = (count_q + inflight) < SW'(FIFO_DEPTH);

  always_comb begin
    logic [IDW-1:0] cand;
    found = 1'b0;
    gid   = '0;
    cand  = '0;
    if (aresetn && credit) begin
      if (state_q == LOCK) begin
        if (s_axis_tvalid[lock_id_q]) begin
          found = 1'b1;
          gid   = lock_id_q;
        end
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
          if (!found && s_axis_tvalid[cand]) begin
            found = 1'b1;
            gid   = cand;
          end
        end
      end
    end
    s_axis_tready = '0;
    if (found) s_axis_tready[gid] = 1'b1;
  end

  assign gid_last = s_axis_tlast[gid];
  assign rr_ptr_d = (gid == IDW'(NUM_REQ - 1)) ? '0 : gid + IDW'(1);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
    end else if (found) begin
      lock_id_q <= gid;
`ifdef ADDER_ARB_PKT_LOCK_EN
      if (gid_last) begin
        state_q  <= IDLE;
        rr_ptr_q <= rr_ptr_d;
      end else begin
        state_q  <= LOCK;
      end
`else
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  // Issue register: one cycle from the s-side handshake to adder_tvalid.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      adder_tvalid_q <= 1'b0;
      adder_tdata_q  <= '0;
      adder_tlast_q  <= 1'b0;
    end else begin
      adder_tvalid_q <= found;
      if (found) begin
        adder_tdata_q <= s_data[gid];
        adder_tlast_q <= gid_last;
      end
    end
  end

  assign adder_tvalid = adder_tvalid_q;
  assign adder_tdata  = adder_tdata_q;
  assign adder_tlast  = adder_tlast_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) tag_vld_q <= '0;
    else          tag_vld_q <= {tag_vld_q[TAGN-2:0], found};
  end

  always_ff @(posedge aclk) begin
    tag_id_q[0] <= gid;
    for (int k = 1; k < TAGN; k++) tag_id_q[k] <= tag_id_q[k-1];
  end

  assign tail_vld = tag_vld_q[TAGN-1];
  assign push     = tail_vld & adder_res_tvalid;
  assign miss     = tail_vld & ~adder_res_tvalid;
  // Results of beats issued before a reset may still drain out of the adder; ignore them.
  assign stray    = adder_res_tvalid & ~tail_vld & (blank_q == '0);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      lat_err_q <= 1'b0;
      blank_q   <= BW'(TAGN);
    end else begin
      if (miss || stray) lat_err_q <= 1'b1;
      if (blank_q != '0) blank_q <= blank_q - BW'(1);
    end
  end

  assign lat_err = lat_err_q;

  // Result FIFO, tagged with the requester id.
  assign fifo_empty = (count_q == '0);
  assign head_id    = fifo_id_q[rd_ptr_q];
  assign pop        = ~fifo_empty & m_axis_tready[head_id];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + SW'(1);
      else if (!push && pop) count_q <= count_q - SW'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_id_q[wr_ptr_q]   <= tag_id_q[TAGN-1];
      fifo_data_q[wr_ptr_q] <= adder_res_tdata;
      fifo_last_q[wr_ptr_q] <= adder_res_tlast;
    end
  end

  always_comb begin
    m_axis_tvalid = '0;
    m_axis_tlast  = '0;
    m_axis_tdata  = '0;
    if (!fifo_empty) begin
      m_axis_tvalid[head_id] = 1'b1;
      m_axis_tlast[head_id]  = fifo_last_q[rd_ptr_q];
      for (int i = 0; i < NUM_REQ; i++) m_axis_tdata[i*DW +: DW] = fifo_data_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter with a behavioural one-cycle adder (optionally one cycle late).
module tb_adder_rr_arbiter;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int LAT = 1;
  localparam int DEPTH = 4;

  typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; logic last; } beat_t;
  typedef struct { int id; logic [DW-1:0] data; logic last; } out_t;
  typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; logic last; logic [DW-1:0] sum; } vec_t;

  logic                aclk = 1'b0;
  logic                aresetn = 1'b0;
  logic [NR*2*DW-1:0]  s_axis_tdata = '0;
  logic [NR-1:0]       s_axis_tvalid = '0;
  logic [NR-1:0]       s_axis_tlast = '0;
  logic [NR-1:0]       s_axis_tready;
  logic [2*DW-1:0]     adder_tdata;
  logic                adder_tvalid, adder_tlast;
  logic [DW-1:0]       adder_res_tdata;
  logic                adder_res_tvalid, adder_res_tlast;
  logic [NR*DW-1:0]    m_axis_tdata;
  logic [NR-1:0]       m_axis_tvalid, m_axis_tlast;
  logic [NR-1:0]       mready = '0;
  logic                lat_err;
  logic                late = 1'b0;

  logic          r1_v = 1'b0, r2_v = 1'b0, r1_l = 1'b0, r2_l = 1'b0;
  logic [DW-1:0] r1_d = '0, r2_d = '0;

  beat_t src_q0[$];
  beat_t src_q1[$];
  int    issue_log[$];
  out_t  out_log[$];
  int    nerr = 0;
  int    nchk = 0;

  adder_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ADDER_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .adder_tdata(adder_tdata), .adder_tvalid(adder_tvalid), .adder_tlast(adder_tlast),
    .adder_res_tdata(adder_res_tdata), .adder_res_tvalid(adder_res_tvalid),
    .adder_res_tlast(adder_res_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(mready), .lat_err(lat_err)
  );

  initial forever #5 aclk = ~aclk;

  always_ff @(posedge aclk) begin
    r1_v <= adder_tvalid;
    r1_d <= adder_tdata[2*DW-1:DW] + adder_tdata[DW-1:0];
    r1_l <= adder_tlast;
    r2_v <= r1_v;
    r2_d <= r1_d;
    r2_l <= r1_l;
  end

  assign adder_res_tvalid = late ? r2_v : r1_v;
  assign adder_res_tdata  = late ? r2_d : r1_d;
  assign adder_res_tlast  = late ? r2_l : r1_l;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last);
    beat_t bt;
    bt.a = a; bt.b = b; bt.last = last;
    if (r == 0) src_q0.push_back(bt);
    else        src_q1.push_back(bt);
  endtask

  task automatic drive();
    if (src_q0.size() > 0) begin
      s_axis_tvalid[0] = 1'b1;
      s_axis_tdata[2*DW-1:0] = {src_q0[0].a, src_q0[0].b};
      s_axis_tlast[0] = src_q0[0].last;
    end else begin
      s_axis_tvalid[0] = 1'b0;
      s_axis_tlast[0]  = 1'b0;
    end
    if (src_q1.size() > 0) begin
      s_axis_tvalid[1] = 1'b1;
      s_axis_tdata[4*DW-1:2*DW] = {src_q1[0].a, src_q1[0].b};
      s_axis_tlast[1] = src_q1[0].last;
    end else begin
      s_axis_tvalid[1] = 1'b0;
      s_axis_tlast[1]  = 1'b0;
    end
  endtask

  // Sample mid-cycle, cross one rising edge, then present the next beats.
  task automatic cycle();
    logic [NR-1:0] hs;
    beat_t dmy;
    out_t  o;
    #1;
    hs = s_axis_tvalid & s_axis_tready;
    for (int i = 0; i < NR; i++) if (hs[i]) issue_log.push_back(i);
    for (int i = 0; i < NR; i++) begin
      if (m_axis_tvalid[i] && mready[i]) begin
        o.id = i; o.data = m_axis_tdata[i*DW +: DW]; o.last = m_axis_tlast[i];
        out_log.push_back(o);
      end
    end
    @(posedge aclk);
    #1;
    if (hs[0] && src_q0.size() > 0) dmy = src_q0.pop_front();
    if (hs[1] && src_q1.size() > 0) dmy = src_q1.pop_front();
    drive();
    @(negedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    src_q0.delete();
    src_q1.delete();
    drive();
    cycle();
    cycle();
    aresetn = 1'b1;
    issue_log.delete();
    out_log.delete();
  endtask

  task automatic wait_out(input int n, input int budget, input string nm);
    int c = 0;
    while (out_log.size() < n && c < budget) begin
      cycle();
      c++;
    end
    chk(nm, out_log.size(), n);
  endtask

  function automatic int iss(input int k);
    return (k < issue_log.size()) ? issue_log[k] : -1;
  endfunction

  function automatic int oid(input int k);
    return (k < out_log.size()) ? out_log[k].id : -1;
  endfunction

  function automatic logic [DW-1:0] odat(input int k);
    return (k < out_log.size()) ? out_log[k].data : 'x;
  endfunction

  function automatic logic olast(input int k);
    return (k < out_log.size()) ? out_log[k].last : 1'bx;
  endfunction

  initial begin
    vec_t vt[4];
    int   exp_issue[6];
    int   n0, n1, id;
    logic [DW-1:0] expd;

    vt[0] = '{a: 32'd5,          b: 32'd7, last: 1'b0, sum: 32'd12};
    vt[1] = '{a: 32'd1,          b: 32'd2, last: 1'b0, sum: 32'd3};
    vt[2] = '{a: 32'hFFFF_FFFF,  b: 32'd1, last: 1'b0, sum: 32'd0};
    vt[3] = '{a: 32'd3,          b: 32'd3, last: 1'b1, sum: 32'd6};
`ifdef ADDER_ARB_PKT_LOCK_EN
    exp_issue = '{0, 0, 0, 1, 1, 1};
`else
    exp_issue = '{0, 1, 0, 1, 0, 1};
`endif

    // Reset state
    @(negedge aclk);
    #1;
    do_reset();
    #1;
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_adder_tvalid", adder_tvalid, 0);
    chk("rst_adder_tdata", adder_tdata, 0);
    chk("rst_adder_tlast", adder_tlast, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_lat_err", lat_err, 0);

    // Single requester, table-driven
    mready = 2'b11;
    for (int k = 0; k < 4; k++) load(0, vt[k].a, vt[k].b, vt[k].last);
    drive();
    #1;
    chk("t1_first_ready", s_axis_tready, 2'b01);
    cycle();
    chk("t1_adder_tvalid", adder_tvalid, 1);
    chk("t1_adder_tdata", adder_tdata, {32'd5, 32'd7});
    wait_out(4, 30, "t1_out_count");
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t1_id[%0d]", k), oid(k), 0);
      chk($sformatf("t1_sum[%0d]", k), odat(k), vt[k].sum);
      chk($sformatf("t1_last[%0d]", k), olast(k), vt[k].last);
    end

    // Two requesters always valid: interleave or packet lock
    do_reset();
    mready = 2'b11;
    for (int k = 1; k <= 3; k++) begin
      load(0, 32'd10, DW'(k), k == 3);
      load(1, 32'd20, DW'(k), k == 3);
    end
    drive();
    wait_out(6, 40, "t2_out_count");
    n0 = 0; n1 = 0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t2_issue[%0d]", k), iss(k), exp_issue[k]);
      id = exp_issue[k];
      if (id == 0) begin expd = DW'(11 + n0); n0++; end
      else         begin expd = DW'(21 + n1); n1++; end
      chk($sformatf("t2_out_id[%0d]", k), oid(k), id);
      chk($sformatf("t2_out_sum[%0d]", k), odat(k), expd);
    end

    // Output stalled: credit limits acceptance to FIFO_DEPTH beats
    do_reset();
    mready = 2'b00;
    for (int k = 1; k <= 6; k++) load(0, DW'(k), 32'd100, k == 6);
    drive();
    repeat (12) cycle();
    chk("t4_accepted", issue_log.size(), DEPTH);
    chk("t4_s_tready", s_axis_tready, 0);
    chk("t4_adder_tvalid", adder_tvalid, 0);
    chk("t4_head_valid", m_axis_tvalid, 2'b01);
    chk("t4_head_data", m_axis_tdata[DW-1:0], 101);
    mready = 2'b11;
    wait_out(6, 40, "t4_out_count");
    chk("t4_issued_total", issue_log.size(), 6);
    for (int k = 0; k < 6; k++) chk($sformatf("t4_sum[%0d]", k), odat(k), DW'(101 + k));
    chk("t4_last", olast(5), 1);

    // Reset for one cycle with two beats in flight
    do_reset();
    mready = 2'b11;
    for (int k = 1; k <= 4; k++) load(0, DW'(k), DW'(k), k == 4);
    drive();
    cycle();
    cycle();
    chk("t5_in_flight", issue_log.size(), 2);
    aresetn = 1'b0;
    src_q0.delete();
    drive();
    cycle();
    aresetn = 1'b1;
    #1;
    chk("t5_adder_tvalid", adder_tvalid, 0);
    chk("t5_adder_tdata", adder_tdata, 0);
    chk("t5_m_tvalid", m_axis_tvalid, 0);
    chk("t5_s_tready", s_axis_tready, 0);
    chk("t5_lat_err", lat_err, 0);
    repeat (4) cycle();
    chk("t5_lat_err_after", lat_err, 0);
    chk("t5_fifo_empty", m_axis_tvalid, 0);
    chk("t5_no_results", out_log.size(), 0);
    load(0, 32'd7, 32'd7, 1'b1);
    load(1, 32'd8, 32'd8, 1'b1);
    drive();
    #1;
    chk("t5_rr_ptr_zero", s_axis_tready, 2'b01);

    // Late adder result sets a sticky error
    do_reset();
    mready = 2'b11;
    late = 1'b1;
    load(0, 32'd2, 32'd3, 1'b1);
    drive();
    repeat (6) cycle();
    chk("t6_lat_err", lat_err, 1);
    chk("t6_no_write", out_log.size(), 0);
    late = 1'b0;
    load(0, 32'd4, 32'd4, 1'b1);
    drive();
    repeat (6) cycle();
    chk("t6_sticky", lat_err, 1);
    chk("t6_recover_count", out_log.size(), 1);
    chk("t6_recover_sum", odat(0), 8);
    do_reset();
    #1;
    chk("t6_cleared", lat_err, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
